// File: rtl/adsr_envelope_pkg.sv
// Shared synth definitions: state encodings, sample format and envelope limits.
// Imported by the envelope stage and by later synth control stages.
package adsr_envelope_pkg;

   localparam int SAMPLE_W = 8;
   localparam logic [SAMPLE_W-1:0] SAMPLE_MID = 8'd128;

   localparam int LEVEL_W = 8;
   localparam logic [LEVEL_W-1:0] LEVEL_MAX = 8'd255;
   localparam logic [LEVEL_W-1:0] LEVEL_MIN = 8'd0;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ATTACK  = 3'd1,
      ST_DECAY   = 3'd2,
      ST_SUSTAIN = 3'd3,
      ST_RELEASE = 3'd4
   } adsr_state_t;

endpackage

// File: rtl/adsr_envelope_tick_divider.sv
// Free-running prescaler: one-cycle tick every TICK_DIV clocks (TICK_DIV >= 2).
// Reusable by any stage that needs a slow periodic step.
module tick_divider #(
   parameter int TICK_DIV = 256
) (
   input  logic clk,
   input  logic reset_n,
   output logic tick
);

   localparam int CNT_W = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [CNT_W-1:0] r_count;
   logic             w_last;

   assign w_last = (r_count == CNT_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_count <= '0;
      end else if (w_last) begin
         r_count <= '0;
      end else begin
         r_count <= r_count + CNT_ONE;
      end
   end

   assign tick = w_last;

endmodule

// File: rtl/adsr_envelope.sv
// ADSR amplitude envelope: gate-driven FSM stepping an 8-bit level on prescaler
// ticks, and a registered scaler applying that level to the oscillator sample.
module adsr_envelope
   import adsr_envelope_pkg::*;
#(
   parameter int TICK_DIV = 256
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                gate,
   input  logic [7:0]          attack_rate,
   input  logic [7:0]          decay_rate,
   input  logic [7:0]          sustain_level,
   input  logic [7:0]          release_rate,
   input  logic [SAMPLE_W-1:0] sample_in,
   output logic [SAMPLE_W-1:0] sample_out,
   output logic [7:0]          envelope,
   output logic [2:0]          state,
   output logic                active
);

   adsr_state_t         r_state;
   adsr_state_t         w_state_next;
   logic [LEVEL_W-1:0]  r_level;
   logic [LEVEL_W-1:0]  w_level_next;
   logic [SAMPLE_W-1:0] r_sample_out;
   logic [SAMPLE_W-1:0] w_sample_next;

   logic                w_tick;
   logic [8:0]          w_att_sum;
   logic [8:0]          w_dec_diff;
   logic [8:0]          w_rel_diff;
   logic [8:0]          w_centered;
   logic [16:0]         w_prod;
   logic                w_unused_prod;

   tick_divider #(
      .TICK_DIV (TICK_DIV)
   ) u_tick (
      .clk     (clk),
      .reset_n (reset_n),
      .tick    (w_tick)
   );

   // 9-bit arithmetic: bit 8 is the carry (attack) or borrow (decay/release).
   assign w_att_sum  = {1'b0, r_level} + {1'b0, attack_rate};
   assign w_dec_diff = {1'b0, r_level} - {1'b0, decay_rate};
   assign w_rel_diff = {1'b0, r_level} - {1'b0, release_rate};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_IDLE;
         r_level <= LEVEL_MIN;
      end else begin
         r_state <= w_state_next;
         r_level <= w_level_next;
      end
   end

   // Gate checks come before tick checks so a coinciding tick is consumed.
   always_comb begin
      w_state_next = r_state;
      w_level_next = r_level;
      case (r_state)
         ST_IDLE: begin
            w_level_next = LEVEL_MIN;
            if (gate) begin
               w_state_next = ST_ATTACK;
            end
         end
         ST_ATTACK: begin
            if (!gate) begin
               w_state_next = ST_RELEASE;
            end else if (w_tick) begin
               if ((attack_rate == 8'd0) || (w_att_sum >= {1'b0, LEVEL_MAX})) begin
                  w_level_next = LEVEL_MAX;
                  w_state_next = ST_DECAY;
               end else begin
                  w_level_next = w_att_sum[7:0];
               end
            end
         end
         ST_DECAY: begin
            if (!gate) begin
               w_state_next = ST_RELEASE;
            end else if (w_tick) begin
               if ((decay_rate == 8'd0) || w_dec_diff[8] ||
                   (w_dec_diff[7:0] <= sustain_level)) begin
                  w_level_next = sustain_level;
                  w_state_next = ST_SUSTAIN;
               end else begin
                  w_level_next = w_dec_diff[7:0];
               end
            end
         end
         ST_SUSTAIN: begin
            if (!gate) begin
               w_state_next = ST_RELEASE;
            end else if (w_tick) begin
               w_level_next = sustain_level;
            end
         end
         ST_RELEASE: begin
            if (gate) begin
               w_state_next = ST_ATTACK;
            end else if (w_tick) begin
               if ((release_rate == 8'd0) || w_rel_diff[8] ||
                   (w_rel_diff[7:0] == 8'd0)) begin
                  w_level_next = LEVEL_MIN;
                  w_state_next = ST_IDLE;
               end else begin
                  w_level_next = w_rel_diff[7:0];
               end
            end
         end
         default: begin
            w_state_next = ST_IDLE;
            w_level_next = LEVEL_MIN;
         end
      endcase
   end

   // Signed sample times unsigned level; bits [15:8] of the product are p >>> 8
   // modulo 256, and adding the midpoint modulo 256 lands exactly in 0..254.
   assign w_centered    = {1'b0, sample_in} - {1'b0, SAMPLE_MID};
   assign w_prod        = {{8{w_centered[8]}}, w_centered} * {9'd0, r_level};
   assign w_sample_next = SAMPLE_MID + w_prod[15:8];
   assign w_unused_prod = ^{w_prod[16], w_prod[7:0]};

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sample_out <= SAMPLE_MID;
      end else begin
         r_sample_out <= w_sample_next;
      end
   end

   assign sample_out = r_sample_out;
   assign envelope   = r_level;
   assign state      = r_state;
   assign active     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_adsr_envelope.sv
// Scoreboard bench for adsr_envelope with TICK_DIV=4: directed stimulus pushes
// expected envelope sequence and cycle-stamped checks; monitors pop and compare.
module tb_adsr_envelope;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       gate;
   logic [7:0] attack_rate;
   logic [7:0] decay_rate;
   logic [7:0] sustain_level;
   logic [7:0] release_rate;
   logic [7:0] sample_in;
   logic [7:0] sample_out;
   logic [7:0] envelope;
   logic [2:0] state;
   logic       active;

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int ph       = 0;

   typedef struct {
      string name;
      int    kind;   // 0 envelope, 1 state, 2 active, 3 sample_out
      int    val;
      int    due;
   } chk_t;

   chk_t chk_q[$];
   int   env_q[$];
   int   env_prev = 0;

   always #5 clk = ~clk;

   adsr_envelope #(.TICK_DIV(4)) dut (
      .clk           (clk),
      .reset_n       (rst_n),
      .gate          (gate),
      .attack_rate   (attack_rate),
      .decay_rate    (decay_rate),
      .sustain_level (sustain_level),
      .release_rate  (release_rate),
      .sample_in     (sample_in),
      .sample_out    (sample_out),
      .envelope      (envelope),
      .state         (state),
      .active        (active)
   );

   always @(posedge clk) cyc <= cyc + 1;

   // Expected prescaler phase, used only to place stimulus relative to ticks.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) ph <= 0;
      else        ph <= (ph + 1) % 4;
   end

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   function automatic int observe(input int kind);
      case (kind)
         0:       return int'(envelope);
         1:       return int'(state);
         2:       return int'(active);
         default: return int'(sample_out);
      endcase
   endfunction

   // Envelope monitor: every change of the output consumes the next expected level.
   always @(negedge clk) begin
      if (envelope !== 8'(env_prev)) begin
         if (env_q.size() == 0) begin
            n_checks++;
            $display("FAIL env_unexpected: got %0d expected no change (cycle %0d)", envelope, cyc);
         end else begin
            check("env_seq", int'(envelope), env_q.pop_front());
         end
         env_prev = int'(envelope);
      end
   end

   // Timed monitor: checks stamped for the current cycle are compared and retired.
   always @(negedge clk) begin
      chk_t keep[$];
      keep = {};
      foreach (chk_q[i]) begin
         if (chk_q[i].due == cyc) check(chk_q[i].name, observe(chk_q[i].kind), chk_q[i].val);
         else keep.push_back(chk_q[i]);
      end
      chk_q = keep;
   end

   function automatic void expect_at(input string name, input int kind, input int val, input int due);
      chk_t c;
      c.name = name; c.kind = kind; c.val = val; c.due = due;
      chk_q.push_back(c);
   endfunction

   function automatic void expect_env_seq(input int vals[$]);
      foreach (vals[i]) env_q.push_back(vals[i]);
   endfunction

   // Cycle whose negedge shows the result of the k-th upcoming tick edge.
   function automatic int tick_due(input int k);
      return cyc + (4 - ph) + 4 * (k - 1);
   endfunction

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic step_to(input int c);
      while (cyc < c) step(1);
   endtask

   task automatic align(input int p);
      while (ph != p) step(1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int t;
      gate = 1'b1; attack_rate = 8'd64; decay_rate = 8'd100;
      sustain_level = 8'd120; release_rate = 8'd50; sample_in = 8'd200;

      // Reset held with gate high and a non-zero sample
      for (int i = 0; i < 3; i++) begin
         step(1);
         expect_at("rst_env", 0, 0, cyc);
         expect_at("rst_state", 1, 0, cyc);
         expect_at("rst_active", 2, 0, cyc);
         expect_at("rst_sample", 3, 128, cyc);
      end
      gate = 1'b0;
      step(1);
      rst_n = 1'b1;

      // Attack 64/tick, decay 100 to sustain 120
      align(1);
      gate = 1'b1;
      expect_at("att_state", 1, 1, cyc + 1);
      expect_at("att_active", 2, 1, cyc + 1);
      expect_at("att_env_t1", 0, 64, tick_due(1));
      expect_at("att_env_peak", 0, 255, tick_due(4));
      expect_at("decay_state", 1, 2, tick_due(4));
      expect_at("decay_env", 0, 155, tick_due(5));
      expect_at("sus_state", 1, 3, tick_due(6));
      expect_at("sus_env", 0, 120, tick_due(6));
      expect_env_seq('{64, 128, 192, 255, 155, 120});
      step_to(tick_due(6));

      // Live sustain tracking down then back up
      sustain_level = 8'd90;
      t = tick_due(1);
      expect_at("sus_track_90", 0, 90, t);
      expect_env_seq('{90});
      step_to(t);
      sustain_level = 8'd120;
      t = tick_due(1);
      expect_env_seq('{120});
      step_to(t);

      // Release 50/tick to idle
      align(1);
      gate = 1'b0;
      expect_at("rel_state", 1, 4, cyc + 1);
      expect_at("rel_active", 2, 1, cyc + 1);
      expect_at("rel_env_t1", 0, 70, tick_due(1));
      expect_at("idle_state", 1, 0, tick_due(3));
      expect_at("idle_active", 2, 0, tick_due(3));
      expect_env_seq('{70, 20, 0});
      step_to(tick_due(3));

      // attack_rate=0 jumps to 255 on the first tick
      align(1);
      attack_rate = 8'd0;
      gate = 1'b1;
      expect_at("att0_env", 0, 255, tick_due(1));
      expect_at("att0_state", 1, 2, tick_due(1));
      expect_at("att0_sus", 1, 3, tick_due(3));
      expect_env_seq('{255, 155, 120});
      step_to(tick_due(3));

      // Release to 70, then retrigger from 70 without returning to 0
      align(1);
      gate = 1'b0;
      t = tick_due(1);
      expect_at("retrig_rel_env", 0, 70, t);
      expect_env_seq('{70});
      step_to(t);
      attack_rate = 8'd64;
      gate = 1'b1;
      expect_at("retrig_state", 1, 1, cyc + 1);
      expect_at("retrig_env", 0, 134, tick_due(1));
      expect_at("retrig_sus", 1, 3, tick_due(5));
      expect_env_seq('{134, 198, 255, 155, 120});
      step_to(tick_due(5));

      // Gate drop on a tick edge: state changes, level holds (no sustain reload)
      align(3);
      sustain_level = 8'd100;
      gate = 1'b0;
      expect_at("coinc_env", 0, 120, cyc + 1);
      expect_at("coinc_state", 1, 4, cyc + 1);
      expect_at("coinc_next_env", 0, 70, tick_due(2));
      expect_at("coinc_idle", 1, 0, tick_due(4));
      expect_env_seq('{70, 20, 0});
      step_to(tick_due(4));

      // Scaling at full level
      sustain_level = 8'd255;
      attack_rate = 8'd0;
      align(1);
      gate = 1'b1;
      expect_at("full_env", 0, 255, tick_due(1));
      expect_at("full_sus", 1, 3, tick_due(2));
      expect_env_seq('{255});
      step_to(tick_due(2));
      sample_in = 8'd255; expect_at("scale255_in255", 3, 254, cyc + 1); step(1);
      sample_in = 8'd0;   expect_at("scale255_in0", 3, 0, cyc + 1);     step(1);

      // Scaling at half level
      sustain_level = 8'd128;
      t = tick_due(1);
      expect_at("half_env", 0, 128, t);
      expect_env_seq('{128});
      step_to(t);
      sample_in = 8'd0;   expect_at("scale128_in0", 3, 64, cyc + 1);    step(1);
      sample_in = 8'd128; expect_at("scale128_in128", 3, 128, cyc + 1); step(1);
      sample_in = 8'd200; expect_at("scale128_in200", 3, 164, cyc + 1); step(1);
      sample_in = 8'd255; expect_at("scale128_in255", 3, 191, cyc + 1); step(1);
      sample_in = 8'd200;

      // Release from 128, attack again, then async reset mid-attack
      align(1);
      gate = 1'b0;
      expect_at("rel2_idle", 1, 0, tick_due(3));
      expect_env_seq('{78, 28, 0});
      step_to(tick_due(3));
      align(1);
      attack_rate = 8'd64;
      gate = 1'b1;
      t = tick_due(2);
      expect_env_seq('{64, 128, 0});
      step_to(t);
      step(1);
      #2;
      rst_n = 1'b0;
      expect_at("midrst_env", 0, 0, cyc);
      expect_at("midrst_state", 1, 0, cyc);
      expect_at("midrst_active", 2, 0, cyc);
      expect_at("midrst_sample", 3, 128, cyc);
      step(2);
      gate = 1'b0;
      rst_n = 1'b1;
      step(3);
      expect_at("post_rst_idle", 1, 0, cyc);
      step(2);

      check("env_q_drained", env_q.size(), 0);
      check("chk_q_drained", chk_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
